// File: rtl/mips32_pkg.sv
// mips32_pkg: shared types for the MIPS32 memory arbiter.
//   arb_state_e : arbiter FSM states (IDLE / BUSY / RESP)
//   owner_e     : which port owns the in-flight access (OWN_IF / OWN_DM)
//   ADDR_W_DEF / DATA_W_DEF : default word-address and data widths
package mips32_pkg;
  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;
endpackage

// File: rtl/mips32_arb_pick.sv
// mips32_arb_pick: combinational grant decision.
//   i_dm_req     : data port requesting
//   i_if_req     : fetch port requesting
//   i_starve_cnt : consecutive DM grants issued while IF was waiting
//   o_vld        : some port wins this cycle
//   o_winner     : the winning port
// DM has priority until it has starved IF for STARVE_MAX grants, then IF
// gets exactly one turn.
module mips32_arb_pick
  import mips32_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic       i_dm_req,
  input  logic       i_if_req,
  input  logic [3:0] i_starve_cnt,
  output logic       o_vld,
  output owner_e     o_winner
);
  always_comb begin
    o_vld    = i_dm_req | i_if_req;
    o_winner = OWN_IF;
    if (i_dm_req && (i_starve_cnt < 4'(STARVE_MAX))) o_winner = OWN_DM;
    else if (i_if_req)                                o_winner = OWN_IF;
    else if (i_dm_req)                                o_winner = OWN_DM;
  end
endmodule

// File: rtl/mips32_mem_arbiter.sv
// mips32_mem_arbiter: shares one single-ported memory between the IF and
// MEM-stage ports, one access in flight at a time.
//   clk1, rst_n                     : clock, async active-low reset
//   if_req/if_addr/if_flush         : fetch request, address, branch flush
//   if_gnt/if_rvalid/if_rdata       : fetch grant pulse, response pulse, data
//   stall_if                        : fetch waiting for grant
//   dm_req/dm_we/dm_addr/dm_wdata   : data request (load/store)
//   dm_gnt/dm_rvalid/dm_rdata       : data grant, completion pulse, load data
//   mem_en/mem_we/mem_addr/mem_wdata: memory strobe and write side
//   mem_rdata                       : memory read data, MEM_LAT after mem_en
// Grant in cycle N, mem_rdata captured at end of N+MEM_LAT, rvalid in
// N+MEM_LAT+1. The RESP cycle also arbitrates so a waiting port is granted
// in N+MEM_LAT+2, giving one access every MEM_LAT+2 cycles.
module mips32_mem_arbiter
  import mips32_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              stall_if,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  arb_state_e        r_state,     w_nxt_state;
  owner_e            r_owner,     w_nxt_owner;
  logic              r_store,     w_nxt_store;
  logic              r_flushed,   w_nxt_flushed;
  logic [2:0]        r_lat_cnt,   w_nxt_lat;
  logic [3:0]        r_starve,    w_nxt_starve;
  logic              r_if_gnt,    w_nxt_if_gnt;
  logic              r_dm_gnt,    w_nxt_dm_gnt;
  logic              r_mem_en,    w_nxt_mem_en;
  logic              r_mem_we,    w_nxt_mem_we;
  logic [ADDR_W-1:0] r_mem_addr,  w_nxt_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata, w_nxt_mem_wdata;
  logic              r_if_rvalid, w_nxt_if_rvalid;
  logic              r_dm_rvalid, w_nxt_dm_rvalid;
  logic [DATA_W-1:0] r_if_rdata,  w_nxt_if_rdata;
  logic [DATA_W-1:0] r_dm_rdata,  w_nxt_dm_rdata;

  logic   w_pick_vld;
  owner_e w_pick_own;
  logic   w_grant;

  mips32_arb_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
    .i_dm_req    (dm_req),
    .i_if_req    (if_req),
    .i_starve_cnt(r_starve),
    .o_vld       (w_pick_vld),
    .o_winner    (w_pick_own)
  );

  // Arbitration happens in IDLE and in the RESP cycle of the previous access.
  assign w_grant = w_pick_vld & ((r_state == IDLE) | (r_state == RESP));

  always_comb begin
    w_nxt_state     = r_state;
    w_nxt_owner     = r_owner;
    w_nxt_store     = r_store;
    w_nxt_flushed   = r_flushed;
    w_nxt_lat       = r_lat_cnt;
    w_nxt_if_gnt    = 1'b0;
    w_nxt_dm_gnt    = 1'b0;
    w_nxt_mem_en    = 1'b0;
    w_nxt_mem_we    = 1'b0;
    w_nxt_mem_addr  = r_mem_addr;
    w_nxt_mem_wdata = r_mem_wdata;
    w_nxt_if_rvalid = 1'b0;
    w_nxt_dm_rvalid = 1'b0;
    w_nxt_if_rdata  = r_if_rdata;
    w_nxt_dm_rdata  = r_dm_rdata;

    if (if_flush && (r_owner == OWN_IF) && (r_state != IDLE)) w_nxt_flushed = 1'b1;

    case (r_state)
      IDLE, RESP: begin
        if (w_grant) begin
          w_nxt_state   = BUSY;
          w_nxt_owner   = w_pick_own;
          w_nxt_flushed = 1'b0;
          w_nxt_lat     = 3'(MEM_LAT);
          w_nxt_mem_en  = 1'b1;
          if (w_pick_own == OWN_DM) begin
            w_nxt_dm_gnt    = 1'b1;
            w_nxt_store     = dm_we;
            w_nxt_mem_we    = dm_we;
            w_nxt_mem_addr  = dm_addr;
            w_nxt_mem_wdata = dm_wdata;
          end else begin
            w_nxt_if_gnt   = 1'b1;
            w_nxt_store    = 1'b0;
            w_nxt_mem_addr = if_addr;
          end
        end else begin
          w_nxt_state = IDLE;
        end
      end
      BUSY: begin
        // The grant cycle itself does not count down, so the final count of 1
        // lands exactly on cycle N+MEM_LAT when mem_rdata is valid.
        if (!r_mem_en) begin
          if (r_lat_cnt == 3'd1) begin
            w_nxt_state = RESP;
            if (r_owner == OWN_IF) begin
              w_nxt_if_rdata  = mem_rdata;
              w_nxt_if_rvalid = ~r_flushed & ~if_flush;
            end else begin
              w_nxt_dm_rdata  = r_store ? '0 : mem_rdata;
              w_nxt_dm_rvalid = 1'b1;
            end
          end else begin
            w_nxt_lat = r_lat_cnt - 3'd1;
          end
        end
      end
      default: w_nxt_state = IDLE;
    endcase
  end

  always_comb begin
    w_nxt_starve = r_starve;
    if (!if_req)                                                   w_nxt_starve = '0;
    else if (w_grant && (w_pick_own == OWN_IF))                    w_nxt_starve = '0;
    else if (w_grant && (w_pick_own == OWN_DM) && (r_starve != 4'hf)) w_nxt_starve = r_starve + 4'd1;
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_owner     <= OWN_IF;
      r_store     <= 1'b0;
      r_flushed   <= 1'b0;
      r_lat_cnt   <= '0;
      r_starve    <= '0;
      r_if_gnt    <= 1'b0;
      r_dm_gnt    <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rvalid <= 1'b0;
      r_dm_rvalid <= 1'b0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
    end else begin
      r_state     <= w_nxt_state;
      r_owner     <= w_nxt_owner;
      r_store     <= w_nxt_store;
      r_flushed   <= w_nxt_flushed;
      r_lat_cnt   <= w_nxt_lat;
      r_starve    <= w_nxt_starve;
      r_if_gnt    <= w_nxt_if_gnt;
      r_dm_gnt    <= w_nxt_dm_gnt;
      r_mem_en    <= w_nxt_mem_en;
      r_mem_we    <= w_nxt_mem_we;
      r_mem_addr  <= w_nxt_mem_addr;
      r_mem_wdata <= w_nxt_mem_wdata;
      r_if_rvalid <= w_nxt_if_rvalid;
      r_dm_rvalid <= w_nxt_dm_rvalid;
      r_if_rdata  <= w_nxt_if_rdata;
      r_dm_rdata  <= w_nxt_dm_rdata;
    end
  end

  assign if_gnt    = r_if_gnt;
  assign dm_gnt    = r_dm_gnt;
  // A flush arriving in the response cycle still kills the pulse.
  assign if_rvalid = r_if_rvalid & ~if_flush;
  assign dm_rvalid = r_dm_rvalid;
  assign if_rdata  = r_if_rdata;
  assign dm_rdata  = r_dm_rdata;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign stall_if  = if_req & ~r_if_gnt;
endmodule

// File: doc/mips32_mem_arbiter.md
# mips32_mem_arbiter

Arbitrates a single-ported unified memory between the instruction-fetch (IF) port and the data-memory (MEM-stage) port of the pipelined MIPS32 core. Supports one outstanding access at a time, with fixed data-port priority and bounded IF starvation. Supports a fetch flush on taken branches. Sits between the pipeline stages and the `Mem` array, and drives the stall request back to IF.

## Interface
- `ADDR_W`, 10: word-address width (1024-word memory).
- `DATA_W`, 32: data width.
- `MEM_LAT`, 2: cycles from `mem_en` to valid `mem_rdata`. Legal range is 1..7.
- `STARVE_MAX`, 4: maximum consecutive DM grants while `if_req` is pending. Legal range is 1..15.

Ports:
- `clk1`, in, 1: single clock. All logic is on the rising edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `if_req`, in, 1: fetch request. Held until `if_gnt`.
- `if_addr`, in, `ADDR_W`: fetch word address.
- `if_flush`, in, 1: taken branch. Discard any in-flight fetch response.
- `if_gnt`, out, 1: one-cycle grant pulse.
- `if_rvalid`, out, 1: one-cycle response pulse.
- `if_rdata`, out, `DATA_W`: fetched instruction.
- `stall_if`, out, 1: `if_req & ~if_gnt` (combinational).
- `dm_req`, in, 1: data request. Held until `dm_gnt`.
- `dm_we`, in, 1: 1 = store, 0 = load.
- `dm_addr`, in, `ADDR_W`: data word address.
- `dm_wdata`, in, `DATA_W`: store data.
- `dm_gnt`, out, 1: one-cycle grant pulse.
- `dm_rvalid`, out, 1: completion pulse, for loads and stores.
- `dm_rdata`, out, `DATA_W`: load data. 0 for stores.
- `mem_en`, out, 1: memory access strobe.
- `mem_we`, out, 1: memory write enable.
- `mem_addr`, out, `ADDR_W`: memory address.
- `mem_wdata`, out, `DATA_W`: memory write data.
- `mem_rdata`, in, `DATA_W`: memory read data.

## Operation
- FSM states:
  - IDLE: no access in flight.
  - BUSY: access in flight, owner latched.
  - RESP: response cycle.
- IDLE grant decision, in priority order:
  - `dm_req && starve_cnt < STARVE_MAX`: grant DM.
  - Else if `if_req`: grant IF.
  - Else if `dm_req`: grant DM.
  - Else stay in IDLE.
- On grant:
  - Drive `<owner>_gnt`=1, `mem_en`=1, `mem_addr`/`mem_we`/`mem_wdata` from the owner's inputs, all registered.
  - Latch `owner` and `flushed`=0.
  - Load `lat_cnt`=`MEM_LAT`.
  - Go to BUSY.
  - `mem_we` is 0 for IF grants.
- BUSY:
  - Decrement `lat_cnt` each cycle.
  - At `lat_cnt`==1, capture `mem_rdata` and go to RESP.
- RESP:
  - Pulse `<owner>_rvalid` with captured data. `dm_rdata`=0 for stores.
  - Return to IDLE.
  - For an IF owner with `flushed`=1, suppress `if_rvalid`.
- `if_flush` sets `flushed` while the owner is IF in BUSY or RESP. In that same cycle, `if_rvalid` is also forced to 0.
- `if_flush` in IDLE has no effect. The requester re-issues with the new address.
- `starve_cnt`:
  - Increments (saturating) on each DM grant while `if_req`=1.
  - Clears on an IF grant, or on any cycle with `if_req`=0.
- Simultaneous `if_req` and `dm_req` in IDLE with `starve_cnt`==`STARVE_MAX`: IF wins, and the DM request stays pending.
- Dropping `req` before grant is a protocol violation. The bench asserts that it never happens.

## Timing
- Reset (async assert, sync deassert handled upstream) forces all of the following:
  - State IDLE.
  - All `*_gnt`, `*_rvalid`, `mem_en`, `mem_we` = 0.
  - `mem_addr`, `mem_wdata`, `if_rdata`, `dm_rdata` = 0.
  - `starve_cnt`=0.
- Reset mid-access discards the in-flight response. No `rvalid` follows.
- Grant is issued in cycle N, with `mem_en` high in cycle N only.
  - `mem_rdata` is sampled at the end of cycle N+`MEM_LAT`.
  - `rvalid` is high in cycle N+`MEM_LAT`+1.
  - The next grant occurs no earlier than cycle N+`MEM_LAT`+2.
- Throughput: one access per `MEM_LAT`+2 cycles.
- Grant latency from request to grant in IDLE is 1 cycle (registered decision).

## Structure
- Shared package `mips32_pkg`:
  - State enum (IDLE/BUSY/RESP).
  - Owner enum (OWN_IF/OWN_DM).
  - Default `ADDR_W`/`DATA_W`.
- Sub-module `mips32_arb_pick` contains the combinational grant decision, taking `dm_req`, `if_req` and `starve_cnt` and producing the winner.
- Everything else sits in the top module.

## Test plan
- Single IF read, addr 0, `Mem[0]`=32'h2801000a, `MEM_LAT`=2: `if_gnt` in cycle N, `if_rvalid` in N+3 with `if_rdata`=32'h2801000a.
- Simultaneous `if_req` (addr 5) and `dm_req` load (addr 8): DM granted first, IF granted 4 cycles later. `stall_if` stays high until `if_gnt`.
- Continuous `dm_req` with `if_req` held, `STARVE_MAX`=4: exactly 4 DM grants, then 1 IF grant, then DM resumes.
- DM store, addr 3, data 32'hdeadbeef, followed by IF read of addr 3: `dm_rvalid` with `dm_rdata`=0, then `if_rdata`=32'hdeadbeef.
- IF read in flight with `if_flush` pulsed in BUSY: no `if_rvalid` for that access. The next IF request (addr 9) completes normally.
- `rst_n` low for 1 cycle during BUSY: all outputs 0 immediately, no `rvalid` afterward, and a new request is granted 1 cycle after reset release.
